// File: rtl/wb_mprj_bridge_if.sv
// ---------------------------------------------------------------------------
// wb_mprj_bridge_if
//
// Bundles the two buses seen by wb_mprj_bridge:
//   - the management-side Wishbone slave port (wbs_*), driven by the
//     management SoC through the user project wrapper;
//   - the user-side per-window slave bus (m_*), one cyc/stb/ack/data lane
//     per slave window, with shared we/sel/adr/write-data.
//
// Modports:
//   slave  : the bridge itself (accepts wbs_* requests, drives m_* strobes,
//            returns wbs_ack_o / wbs_dat_o)
//   master : the environment around the bridge (management master and the
//            user slaves)
//
// Parameters:
//   NSLV   : number of slave windows
//   SLV_AW : byte-address width of each slave window
// ---------------------------------------------------------------------------
interface wb_mprj_bridge_if #(
  parameter int NSLV   = 4,
  parameter int SLV_AW = 20
);

  // Management-side request / response
  logic                   wbs_cyc_i;
  logic                   wbs_stb_i;
  logic                   wbs_we_i;
  logic [3:0]             wbs_sel_i;
  logic [31:0]            wbs_adr_i;
  logic [31:0]            wbs_dat_i;
  logic                   wbs_ack_o;
  logic [31:0]            wbs_dat_o;

  // User-side slave windows
  logic [NSLV-1:0]        m_cyc_o;
  logic [NSLV-1:0]        m_stb_o;
  logic                   m_we_o;
  logic [3:0]             m_sel_o;
  logic [SLV_AW-1:0]      m_adr_o;
  logic [31:0]            m_dat_o;
  logic [32*NSLV-1:0]     m_dat_i;
  logic [NSLV-1:0]        m_ack_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    input  m_dat_i, m_ack_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    output m_dat_i, m_ack_i
  );

endinterface

// File: rtl/wb_mprj_bridge.sv
// ---------------------------------------------------------------------------
// wb_mprj_bridge
//
// Wishbone bridge from the management SoC slave port of the user project
// wrapper to NSLV user-side slave windows. A request is decoded into a slave
// index, registered, and held on that slave's cyc/stb until it acks or a bus
// timeout expires. The management side always gets exactly one registered
// ack per accepted request; decode misses and timeouts are answered with
// fixed error data, pulse err_irq_o and bump a saturating error counter, so
// the management core never hangs on a dead user slave.
//
// Ports:
//   wb_clk_i   : clock
//   wb_rst_i   : synchronous active-high reset, clears state and all outputs
//   bus        : wb_mprj_bridge_if.slave
//                  wbs_* : management request in, ack / read data out
//                  m_*   : one-hot per-window cyc/stb, latched we/sel/adr/data,
//                          per-window read data and acks in
//   err_irq_o  : one-cycle pulse per decode miss or timeout (in its ack cycle)
//   err_cnt_o  : saturating count of error terminations
//
// Parameters:
//   NSLV    : number of slave windows (power of two, 2..16)
//   BASE    : user-area base; address bits above SLV_AW+log2(NSLV) must match
//   SLV_AW  : byte-address width of each slave window
//   TIMEOUT : REQ cycles without ack before forced termination (1..65535)
// ---------------------------------------------------------------------------
module wb_mprj_bridge #(
  parameter int          NSLV    = 4,
  parameter logic [31:0] BASE    = 32'h3000_0000,
  parameter int          SLV_AW  = 20,
  parameter int          TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_mprj_bridge_if.slave       bus,
  output logic                  err_irq_o,
  output logic [7:0]            err_cnt_o
);

  localparam int          IDX_W    = $clog2(NSLV);
  // Lowest address bit that has to match BASE for a decode hit.
  localparam int          HI_LSB   = SLV_AW + IDX_W;
  localparam logic [15:0] TERM_CNT = 16'(TIMEOUT - 1);

  localparam logic [31:0] MISS_DATA    = 32'hBADD_ADD0;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [15:0]         tcnt_q,  tcnt_d;
  logic [NSLV-1:0]     stb_q,   stb_d;
  logic                we_q,    we_d;
  logic [3:0]          sel_q,   sel_d;
  logic [SLV_AW-1:0]   adr_q,   adr_d;
  logic [31:0]         wdat_q,  wdat_d;
  logic [31:0]         rdat_q,  rdat_d;
  logic                ack_q,   ack_d;
  logic                err_q,   err_d;
  logic [7:0]          ecnt_q,  ecnt_d;

  logic                req_hit;
  logic [IDX_W-1:0]    req_idx;
  logic                sel_ack;
  logic [31:0]         sel_dat;

  // Address decode of the incoming management request.
  assign req_hit = (bus.wbs_adr_i[31:HI_LSB] == BASE[31:HI_LSB]);
  assign req_idx = bus.wbs_adr_i[HI_LSB-1:SLV_AW];

  // Ack/data of the currently selected window; acks from every other
  // window are simply not looked at.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = 32'h0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ack = bus.m_ack_i[i];
        sel_dat = bus.m_dat_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    ecnt_d  = ecnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          // The slave-side latches follow every accepted request, hit or miss.
          we_d   = bus.wbs_we_i;
          sel_d  = bus.wbs_sel_i;
          adr_d  = bus.wbs_adr_i[SLV_AW-1:0];
          wdat_d = bus.wbs_dat_i;
          if (req_hit) begin
            idx_d   = req_idx;
            tcnt_d  = 16'h0;
            stb_d   = NSLV'(1) << req_idx;
            state_d = REQ;
          end else begin
            rdat_d  = MISS_DATA;
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      REQ: begin
        tcnt_d = tcnt_q + 16'd1;
        if (!bus.wbs_cyc_i) begin
          // Master gave up: release the slave silently.
          stb_d   = '0;
          state_d = IDLE;
        end else if (sel_ack) begin
          // Checked before the terminal count so a last-cycle ack still wins.
          stb_d   = '0;
          rdat_d  = we_q ? 32'h0 : sel_dat;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (tcnt_q == TERM_CNT) begin
          stb_d   = '0;
          rdat_d  = TIMEOUT_DATA;
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        stb_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (err_d && (ecnt_q != 8'hFF)) begin
      ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tcnt_q  <= 16'h0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= '0;
      wdat_q  <= 32'h0;
      rdat_q  <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  // cyc and stb are the same one-hot vector: a window is either being
  // addressed or left completely alone.
  assign bus.m_cyc_o   = stb_q;
  assign bus.m_stb_o   = stb_q;
  assign bus.m_we_o    = we_q;
  assign bus.m_sel_o   = sel_q;
  assign bus.m_adr_o   = adr_q;
  assign bus.m_dat_o   = wdat_q;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = rdat_q;
  assign err_irq_o     = err_q;
  assign err_cnt_o     = ecnt_q;

  a_stb_onehot: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    $onehot0(stb_q));
  a_ack_single: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    !(ack_q && $past(ack_q)));

endmodule

// File: tb/tb_wb_mprj_bridge.sv
`timescale 1ns/1ps
module tb_wb_mprj_bridge;

  localparam int          NSLV   = 4;
  localparam int          SLV_AW = 20;
  localparam int          IDXW   = 2;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          TO_A   = 255;
  localparam int          LIMIT  = 300;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       err_irq_a, err_irq_b;
  logic [7:0] err_cnt_a, err_cnt_b;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_mprj_bridge_if #(.NSLV(NSLV), .SLV_AW(SLV_AW)) bA ();
  wb_mprj_bridge_if #(.NSLV(NSLV), .SLV_AW(SLV_AW)) bB ();

  wb_mprj_bridge #(.NSLV(NSLV), .BASE(BASE), .SLV_AW(SLV_AW), .TIMEOUT(TO_A)) dut_a (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .bus(bA.slave),
    .err_irq_o(err_irq_a), .err_cnt_o(err_cnt_a));

  wb_mprj_bridge #(.NSLV(NSLV), .BASE(BASE), .SLV_AW(SLV_AW), .TIMEOUT(1)) dut_b (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .bus(bB.slave),
    .err_irq_o(err_irq_b), .err_cnt_o(err_cnt_b));

  // Behavioural user slaves for DUT A: slave i acks after wait_a[i] wait
  // states of its strobe (-1 = never); unselected slaves emit noise acks.
  int              wait_a [NSLV];
  logic [31:0]     sdat_a [NSLV];
  logic [NSLV-1:0] noise = '0;
  int              scnt = 0;

  always @(posedge wb_clk_i) scnt <= (bA.m_stb_o != '0) ? scnt + 1 : 0;

  always_comb begin
    bA.m_ack_i = '0;
    bA.m_dat_i = '0;
    for (int i = 0; i < NSLV; i++) begin
      bA.m_ack_i[i] = bA.m_stb_o[i] ? (wait_a[i] >= 0 && scnt == wait_a[i]) : noise[i];
      bA.m_dat_i[32*i +: 32] = sdat_a[i];
    end
  end

  assign bB.m_ack_i = '0;
  assign bB.m_dat_i = '0;

  int n_chk = 0;
  int n_err = 0;
  int ecnt_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Observed results of one transfer on DUT A.
  int                r_lat, r_stb, r_acks, r_irq;
  logic              r_irq_ack, r_cyc_ok, r_mwe;
  logic [31:0]       r_rd, r_mdat;
  logic [7:0]        r_ecnt;
  logic [NSLV-1:0]   r_oh;
  logic [SLV_AW-1:0] r_madr;
  logic [3:0]        r_msel;

  // Entry: #1 after a posedge with DUT A idle; the request is sampled at the
  // next edge (edge 0), cycle c is observed #1 after edge c-1.
  task automatic run_a(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] wdat);
    bA.wbs_cyc_i = 1'b1; bA.wbs_stb_i = 1'b1; bA.wbs_we_i = we;
    bA.wbs_sel_i = sel;  bA.wbs_adr_i = adr;  bA.wbs_dat_i = wdat;
    r_lat = -1; r_stb = 0; r_acks = 0; r_irq = 0; r_irq_ack = 1'b0; r_cyc_ok = 1'b1;
    r_rd = '0; r_ecnt = '0;
    for (int c = 1; c <= LIMIT; c++) begin
      tick();
      if (c == 1) begin
        r_oh = bA.m_stb_o; r_madr = bA.m_adr_o; r_mwe = bA.m_we_o;
        r_msel = bA.m_sel_o; r_mdat = bA.m_dat_o;
      end
      if (bA.m_stb_o != '0) r_stb++;
      if (bA.m_cyc_o != bA.m_stb_o) r_cyc_ok = 1'b0;
      if (err_irq_a) r_irq++;
      if (bA.wbs_ack_o) begin
        r_acks++;
        if (r_lat < 0) begin
          r_lat = c; r_rd = bA.wbs_dat_o; r_ecnt = err_cnt_a; r_irq_ack = err_irq_a;
        end
        bA.wbs_cyc_i = 1'b0; bA.wbs_stb_i = 1'b0;
      end
      if (r_lat >= 0 && c == r_lat + 1) break;
    end
    if (r_lat < 0) begin
      bA.wbs_cyc_i = 1'b0; bA.wbs_stb_i = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic compare(input string tag, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] wdat,
                         input int e_lat, input logic [31:0] e_rd, input int e_stb,
                         input logic [NSLV-1:0] e_oh, input int e_irq);
    ecnt_m = (ecnt_m + e_irq > 255) ? 255 : ecnt_m + e_irq;
    chk({tag, "_lat"},     r_lat, e_lat);
    chk({tag, "_rdata"},   r_rd, e_rd);
    chk({tag, "_acks"},    r_acks, 1);
    chk({tag, "_stbcyc"},  r_stb, e_stb);
    chk({tag, "_onehot"},  r_oh, e_oh);
    chk({tag, "_cyc_eq"},  r_cyc_ok, 1);
    chk({tag, "_irqs"},    r_irq, e_irq);
    chk({tag, "_irq_ack"}, r_irq_ack, e_irq);
    chk({tag, "_errcnt"},  r_ecnt, ecnt_m);
    chk({tag, "_m_adr"},   r_madr, adr[SLV_AW-1:0]);
    chk({tag, "_m_we"},    r_mwe, we);
    chk({tag, "_m_sel"},   r_msel, sel);
    chk({tag, "_m_dat"},   r_mdat, wdat);
  endtask

  // Reference: a hit addresses slave adr/2^SLV_AW mod NSLV, which answers after
  // its wait states unless that exceeds the TIMEOUT-strobe deadline.
  function automatic void ref_xfer(input logic we, input logic [31:0] adr,
                                   output int lat, output logic [31:0] rd, output int stb,
                                   output logic [NSLV-1:0] oh, output int irq);
    int slv;
    int wt;
    slv = int'((adr >> SLV_AW) % NSLV);
    oh  = '0;
    if ((adr >> (SLV_AW + IDXW)) != (BASE >> (SLV_AW + IDXW))) begin
      lat = 1; rd = 32'hBADD_ADD0; stb = 0; irq = 1;
    end else begin
      oh[slv] = 1'b1;
      wt = wait_a[slv];
      if (wt >= 0 && wt < TO_A) begin
        stb = wt + 1; lat = wt + 2; rd = we ? 32'h0 : sdat_a[slv]; irq = 0;
      end else begin
        stb = TO_A; lat = TO_A + 1; rd = 32'hDEAD_BEEF; irq = 1;
      end
    end
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"},   bA.wbs_ack_o, 0);
    chk({tag, "_dat_o"}, bA.wbs_dat_o, 0);
    chk({tag, "_m_cyc"}, bA.m_cyc_o, 0);
    chk({tag, "_m_stb"}, bA.m_stb_o, 0);
    chk({tag, "_m_we"},  bA.m_we_o, 0);
    chk({tag, "_m_sel"}, bA.m_sel_o, 0);
    chk({tag, "_m_adr"}, bA.m_adr_o, 0);
    chk({tag, "_m_dat"}, bA.m_dat_o, 0);
    chk({tag, "_irq"},   err_irq_a, 0);
    chk({tag, "_cnt"},   err_cnt_a, 0);
  endtask

  typedef struct packed {
    logic            we;
    logic [3:0]      sel;
    logic [31:0]     adr;
    logic [31:0]     wdat;
    int              slv_wait;
    logic [31:0]     sdat;
    logic [NSLV-1:0] noise;
    int              e_lat;
    logic [31:0]     e_rd;
    int              e_stb;
    logic [NSLV-1:0] e_oh;
    int              e_irq;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  logic [31:0]     ra, rwd, base_v;
  logic [3:0]      rsel;
  logic            rwe;
  int              rslv, tsel, e_lat, e_stb, e_irq, cnt_a, cnt_i;
  logic [31:0]     e_rd;
  logic [NSLV-1:0] e_oh;
  int              b_lat, b_acks, b_irq;
  logic [31:0]     b_rd;
  logic [7:0]      b_cnt, cnt_before;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    base_v = BASE;
    //       we   sel      adr            wdat           wait sdat           noise    lat  rd             stb  oh       irq
    vt[0] = '{1'b0, 4'hF,    32'h3020_0010, 32'h0000_0000, 1,   32'h1234_5678, 4'b0000, 3,   32'h1234_5678, 2,   4'b0100, 0};
    vt[1] = '{1'b1, 4'b0011, 32'h3000_0004, 32'hA5A5_A5A5, 0,   32'hCAFE_F00D, 4'b0000, 2,   32'h0000_0000, 1,   4'b0001, 0};
    vt[2] = '{1'b0, 4'hF,    32'h2000_0000, 32'h0000_0000, 0,   32'h1111_1111, 4'b0000, 1,   32'hBADD_ADD0, 0,   4'b0000, 1};
    vt[3] = '{1'b0, 4'hF,    32'h3030_0000, 32'h0000_0000, -1,  32'h2222_2222, 4'b0111, 256, 32'hDEAD_BEEF, 255, 4'b1000, 1};
    vt[4] = '{1'b0, 4'hF,    32'h3030_0008, 32'h0000_0000, 254, 32'h3333_3333, 4'b0000, 256, 32'h3333_3333, 255, 4'b1000, 0};
    vt[5] = '{1'b0, 4'b1000, 32'h301F_FFFC, 32'h5555_0000, 3,   32'h4444_4444, 4'b1101, 5,   32'h4444_4444, 4,   4'b0010, 0};
    vt[6] = '{1'b1, 4'hF,    32'h3040_0000, 32'h6666_6666, 0,   32'h0000_0000, 4'b0000, 1,   32'hBADD_ADD0, 0,   4'b0000, 1};
    vt[7] = '{1'b1, 4'b0100, 32'h2FFF_FFFC, 32'h7777_7777, 0,   32'h0000_0000, 4'b0000, 1,   32'hBADD_ADD0, 0,   4'b0000, 1};
    vt[8] = '{1'b1, 4'hF,    32'h3020_0000, 32'h8888_8888, 2,   32'h9999_9999, 4'b1011, 4,   32'h0000_0000, 3,   4'b0100, 0};

    for (int i = 0; i < NSLV; i++) begin wait_a[i] = 0; sdat_a[i] = 32'h0; end
    bA.wbs_cyc_i = 1'b0; bA.wbs_stb_i = 1'b0; bA.wbs_we_i = 1'b0;
    bA.wbs_sel_i = 4'h0; bA.wbs_adr_i = 32'h0; bA.wbs_dat_i = 32'h0;
    bB.wbs_cyc_i = 1'b0; bB.wbs_stb_i = 1'b0; bB.wbs_we_i = 1'b0;
    bB.wbs_sel_i = 4'hF; bB.wbs_adr_i = 32'h3010_0000; bB.wbs_dat_i = 32'h0;

    // Reset state
    wb_rst_i = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    chk("reset_b_cnt", err_cnt_b, 0);
    chk("reset_b_ack", bB.wbs_ack_o, 0);
    wb_rst_i = 1'b0;

    // Directed vectors
    for (int v = 0; v < NV; v++) begin
      tsel = int'((vt[v].adr >> SLV_AW) % NSLV);
      for (int i = 0; i < NSLV; i++) begin
        wait_a[i] = vt[v].slv_wait;
        sdat_a[i] = (i == tsel) ? vt[v].sdat : ~vt[v].sdat;
      end
      noise = vt[v].noise;
      run_a(vt[v].we, vt[v].sel, vt[v].adr, vt[v].wdat);
      compare($sformatf("vec%0d", v), vt[v].we, vt[v].sel, vt[v].adr, vt[v].wdat,
              vt[v].e_lat, vt[v].e_rd, vt[v].e_stb, vt[v].e_oh, vt[v].e_irq);
    end
    noise = '0;

    // Master abort mid-REQ
    for (int i = 0; i < NSLV; i++) wait_a[i] = -1;
    bA.wbs_cyc_i = 1'b1; bA.wbs_stb_i = 1'b1; bA.wbs_we_i = 1'b0; bA.wbs_adr_i = 32'h3020_0040;
    tick();
    chk("abort_stb_c1", bA.m_stb_o, 4'b0100);
    tick(); tick();
    chk("abort_stb_c3", bA.m_stb_o, 4'b0100);
    bA.wbs_cyc_i = 1'b0; bA.wbs_stb_i = 1'b0;
    tick();
    chk("abort_stb_drop", bA.m_stb_o, 0);
    chk("abort_cyc_drop", bA.m_cyc_o, 0);
    cnt_a = 0; cnt_i = 0;
    for (int c = 0; c < 6; c++) begin
      if (bA.wbs_ack_o) cnt_a++;
      if (err_irq_a) cnt_i++;
      tick();
    end
    chk("abort_no_ack", cnt_a, 0);
    chk("abort_no_irq", cnt_i, 0);
    chk("abort_errcnt", err_cnt_a, ecnt_m);

    // Reset mid-REQ, then a normal read
    bA.wbs_cyc_i = 1'b1; bA.wbs_stb_i = 1'b1; bA.wbs_we_i = 1'b1;
    bA.wbs_sel_i = 4'b1010; bA.wbs_adr_i = 32'h3010_0020; bA.wbs_dat_i = 32'hF0F0_F0F0;
    tick(); tick();
    chk("rst_pre_stb", bA.m_stb_o, 4'b0010);
    chk("rst_pre_cnt", err_cnt_a, ecnt_m);
    wb_rst_i = 1'b1; bA.wbs_cyc_i = 1'b0; bA.wbs_stb_i = 1'b0;
    tick();
    chk_zero("rst_mid");
    wb_rst_i = 1'b0;
    ecnt_m = 0;
    for (int i = 0; i < NSLV; i++) begin wait_a[i] = i; sdat_a[i] = 32'hC0DE_0000 + i; end
    ref_xfer(1'b0, 32'h3010_0100, e_lat, e_rd, e_stb, e_oh, e_irq);
    run_a(1'b0, 4'hF, 32'h3010_0100, 32'h0BAD_0BAD);
    compare("post_rst", 1'b0, 4'hF, 32'h3010_0100, 32'h0BAD_0BAD, e_lat, e_rd, e_stb, e_oh, e_irq);

    // Randomized transfers against the reference model
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NSLV; i++) begin
        wait_a[i] = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 5));
        sdat_a[i] = $urandom;
      end
      noise = NSLV'($urandom);
      rslv  = int'($urandom_range(0, NSLV - 1));
      rwe   = 1'($urandom);
      rsel  = 4'($urandom);
      rwd   = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = $urandom;
        if (ra[31:22] == base_v[31:22]) ra[31] = ~ra[31];
      end else begin
        ra = {base_v[31:22], 2'(rslv), 20'($urandom)};
      end
      ref_xfer(rwe, ra, e_lat, e_rd, e_stb, e_oh, e_irq);
      run_a(rwe, rsel, ra, rwd);
      compare($sformatf("rnd%0d", k), rwe, rsel, ra, rwd, e_lat, e_rd, e_stb, e_oh, e_irq);
    end
    noise = '0;

    // TIMEOUT=1 instance: every transfer times out; counter saturates
    b_irq = 0;
    for (int n = 1; n <= 300; n++) begin
      b_lat = -1; b_acks = 0; b_rd = '0; b_cnt = '0;
      cnt_before = err_cnt_b;
      bB.wbs_cyc_i = 1'b1; bB.wbs_stb_i = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (err_irq_b) b_irq++;
        if (bB.wbs_ack_o) begin
          b_acks++;
          if (b_lat < 0) begin b_lat = c; b_rd = bB.wbs_dat_o; b_cnt = err_cnt_b; end
          bB.wbs_cyc_i = 1'b0; bB.wbs_stb_i = 1'b0;
        end
        if (b_lat >= 0 && c == b_lat + 1) break;
      end
      bB.wbs_cyc_i = 1'b0; bB.wbs_stb_i = 1'b0;
      chk($sformatf("b%0d_lat", n), b_lat, 2);
      chk($sformatf("b%0d_acks", n), b_acks, 1);
      chk($sformatf("b%0d_cnt", n), b_cnt, (n > 255) ? 255 : n);
      if (n == 1 || n == 300) chk($sformatf("b%0d_rdata", n), b_rd, 32'hDEAD_BEEF);
      if (n == 1) chk("b1_cnt_before", cnt_before, 0);
    end
    chk("b_irq_total", b_irq, 300);
    chk("b_final_cnt", err_cnt_b, 255);
    chk("b_idle_stb", bB.m_stb_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
